// File: rtl/gfx_mem_ctrl.sv
// gfx_mem_ctrl
//   Graphics memory controller with a CPU bus port, a VGA read port and a
//   hardware fill engine around an inferred true dual-port RAM.
//   - Port A is shared by the bus and the fill engine.
//   - Port B is a free-running VGA read port.
//   Optional feature macro: GFX_SCROLL_EN. When it is defined, the
//   scroll_off_i port is added and VGA addresses are offset by it, wrapping
//   at DEPTH.

module gfx_mem_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 13,
  parameter int DEPTH = 4800
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // CPU bus port
  input  logic          bus_req_i,
  input  logic          bus_we_i,
  input  logic [AW-1:0] bus_addr_i,
  input  logic [DW-1:0] bus_data_i,
  output logic          bus_ack_o,
  output logic [DW-1:0] bus_data_o,
  // VGA read port
  input  logic          vga_rd_i,
  input  logic [AW-1:0] vga_addr_i,
`ifdef GFX_SCROLL_EN
  input  logic [AW-1:0] scroll_off_i,
`endif
  output logic [DW-1:0] vga_data_o,
  output logic          vga_valid_o,
  // Fill engine
  input  logic          fill_start_i,
  input  logic [AW-1:0] fill_base_i,
  input  logic [AW:0]   fill_len_i,
  input  logic [DW-1:0] fill_value_i,
  output logic          fill_busy_o,
  output logic          fill_done_o
);

  // Port-A FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  // Address-range constants. One extra bit keeps the comparisons exact even
  // when DEPTH equals 2**AW.
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

  // Storage. It is deliberately never cleared, so it maps onto block RAM.
  logic [DW-1:0] mem [DEPTH];

  // FSM and fill engine state
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] fillAddr_q, fillAddr_d;
  logic [AW:0]   fillCnt_q, fillCnt_d;
  logic [DW-1:0] fillVal_q, fillVal_d;
  logic          fillDone_q, fillDone_d;

  // Attributes of the bus transaction being acknowledged
  logic          busWe_q, busWe_d;
  logic          busOob_q, busOob_d;

  // Port-A access controls
  logic          aWe;
  logic          aRe;
  logic [AW-1:0] aAddr;
  logic [DW-1:0] aWdata;
  logic [DW-1:0] ramQA;

  // Port-B read path
  logic [AW-1:0] vgaEff;
  logic [AW-1:0] vgaRdAddr;
  logic          vgaInRange;
  logic [DW-1:0] ramQB;
  logic          vgaValid_q;
  logic          vgaZero_q;

  // Address helpers
  logic          busInRange;
  logic [AW-1:0] fillBaseAdj;
  logic [AW-1:0] fillAddrNext;

  assign busInRange = ({1'b0, bus_addr_i} < DEPTH_W);

  // A base past the end is folded back by one DEPTH.
  assign fillBaseAdj = ({1'b0, fill_base_i} >= DEPTH_W)
                       ? AW'({1'b0, fill_base_i} - DEPTH_W)
                       : fill_base_i;

  assign fillAddrNext = (fillAddr_q == LAST_ADDR) ? '0 : fillAddr_q + 1'b1;

  assign vgaInRange = ({1'b0, vga_addr_i} < DEPTH_W);

`ifdef GFX_SCROLL_EN
  logic [AW:0] vgaSum;
  assign vgaSum = {1'b0, vga_addr_i} + {1'b0, scroll_off_i};
  assign vgaEff = (vgaSum >= DEPTH_W) ? AW'(vgaSum - DEPTH_W) : vgaSum[AW-1:0];
`else
  assign vgaEff = vga_addr_i;
`endif

  // Out-of-range VGA reads are redirected to word 0 and masked at the output.
  assign vgaRdAddr = vgaInRange ? vgaEff : '0;

  // Next-state logic for the port-A FSM. It also decides who owns port A
  // this cycle. When both arrive together, a fill start beats a bus request.
  always_comb begin
    state_d    = state_q;
    fillAddr_d = fillAddr_q;
    fillCnt_d  = fillCnt_q;
    fillVal_d  = fillVal_q;
    fillDone_d = 1'b0;
    busWe_d    = busWe_q;
    busOob_d   = busOob_q;
    aWe        = 1'b0;
    aRe        = 1'b0;
    aAddr      = bus_addr_i;
    aWdata     = bus_data_i;

    case (state_q)
      ST_IDLE: begin
        if (fill_start_i) begin
          if (fill_len_i == '0) begin
            fillDone_d = 1'b1;
          end else begin
            fillAddr_d = fillBaseAdj;
            fillCnt_d  = fill_len_i;
            fillVal_d  = fill_value_i;
            state_d    = ST_FILL;
          end
        end else if (bus_req_i) begin
          busWe_d  = bus_we_i;
          busOob_d = ~busInRange;
          aWe      = bus_we_i & busInRange;
          aRe      = ~bus_we_i & busInRange;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      ST_FILL: begin
        aWe        = 1'b1;
        aAddr      = fillAddr_q;
        aWdata     = fillVal_q;
        fillAddr_d = fillAddrNext;
        fillCnt_d  = fillCnt_q - CNT_ONE;
        if (fillCnt_q == CNT_ONE) begin
          state_d    = ST_IDLE;
          fillDone_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A reset edge aborts whatever port A was about to do.
    if (rst_i) begin
      aWe = 1'b0;
      aRe = 1'b0;
    end
  end

  // FSM, fill engine and bus-transaction registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      fillAddr_q <= '0;
      fillCnt_q  <= '0;
      fillVal_q  <= '0;
      fillDone_q <= 1'b0;
      busWe_q    <= 1'b0;
      busOob_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fillAddr_q <= fillAddr_d;
      fillCnt_q  <= fillCnt_d;
      fillVal_q  <= fillVal_d;
      fillDone_q <= fillDone_d;
      busWe_q    <= busWe_d;
      busOob_q   <= busOob_d;
    end
  end

  // RAM port A: a write from the bus or the fill engine, or a bus read
  always_ff @(posedge clk_i) begin
    if (aWe) begin
      mem[aAddr] <= aWdata;
    end
    if (aRe) begin
      ramQA <= mem[aAddr];
    end
  end

  // RAM port B: a VGA read. It returns old data when port A writes the
  // same word on the same edge.
  always_ff @(posedge clk_i) begin
    if (vga_rd_i) begin
      ramQB <= mem[vgaRdAddr];
    end
  end

  // VGA valid pulse, plus the mask that forces zero after reset or after an
  // out-of-range read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vgaValid_q <= 1'b0;
      vgaZero_q  <= 1'b1;
    end else begin
      vgaValid_q <= vga_rd_i;
      if (vga_rd_i) begin
        vgaZero_q <= ~vgaInRange;
      end
    end
  end

  assign bus_ack_o   = (state_q == ST_ACK);
  assign bus_data_o  = (bus_ack_o && !busWe_q && !busOob_q) ? ramQA : '0;
  assign fill_busy_o = (state_q == ST_FILL);
  assign fill_done_o = fillDone_q;
  assign vga_valid_o = vgaValid_q;
  assign vga_data_o  = vgaZero_q ? '0 : ramQB;

endmodule
